// File: rtl/pwm_peripheral_if.sv
// Configuration and output bundle between the SPI register file (master)
// and the PWM output stage (slave).
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-channel output stage: each pin is off, static high, or driven by one
// shared 8-bit PWM whose duty is latched only at period boundaries.
module pwm_peripheral #(
  parameter int CLK_DIV = 3000
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_peripheral_if.slave   io_bus
);

  localparam int              PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [7:0]    r_cnt;
  logic [7:0]    r_duty_shadow;
  logic [15:0]   r_out;
  logic          r_period_start;

  logic          w_tick;
  logic          w_pstart;
  logic [7:0]    w_duty_eff;
  logic          w_pwm_raw;
  logic [15:0]   w_en_out;
  logic [15:0]   w_en_pwm;
  logic [15:0]   w_out_next;

  assign w_tick   = (r_presc == PRESC_MAX);
  assign w_pstart = (r_cnt == 8'd0) && (r_presc == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the asynchronous clear acts the instant rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_shadow <= 8'h00;
    end else if (w_pstart) begin
      r_duty_shadow <= io_bus.pwm_duty_cycle;
    end
  end

  // The duty presented during the boundary cycle governs that whole period.
  assign w_duty_eff = w_pstart ? io_bus.pwm_duty_cycle : r_duty_shadow;
  assign w_pwm_raw  = (w_duty_eff == 8'hFF) ? 1'b1 : (r_cnt < w_duty_eff);

  assign w_en_out   = {io_bus.en_reg_out_15_8, io_bus.en_reg_out_7_0};
  assign w_en_pwm   = {io_bus.en_reg_pwm_15_8, io_bus.en_reg_pwm_7_0};
  assign w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_raw}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out          <= 16'h0000;
      r_period_start <= 1'b0;
    end else begin
      r_out          <= w_out_next;
      r_period_start <= w_pstart;
    end
  end

  assign io_bus.out          = r_out;
  assign io_bus.period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: two instances (CLK_DIV=4 and 1) checked
// every clock against a period-position model through a scoreboard queue.
module tb_pwm_peripheral;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
  localparam int PER_A = 256 * DIV_A;
  localparam int PER_B = 256 * DIV_B;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_peripheral_if if_a ();
  pwm_peripheral_if if_b ();

  pwm_peripheral #(.CLK_DIV(DIV_A)) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(if_a));
  pwm_peripheral #(.CLK_DIV(DIV_B)) dut_b (.clk(clk), .rst_n(rst_n), .io_bus(if_b));

  typedef struct {
    logic [15:0] out_a;
    logic        ps_a;
    logic [15:0] out_b;
    logic        ps_b;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;

  // Model state: clocks since reset release and the duty latched per instance.
  int          m_t;
  logic [7:0]  m_duty_a;
  logic [7:0]  m_duty_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_out = eo;
    en_pwm = ep;
    duty   = d;
    if_a.en_reg_out_7_0  = eo[7:0];
    if_a.en_reg_out_15_8 = eo[15:8];
    if_a.en_reg_pwm_7_0  = ep[7:0];
    if_a.en_reg_pwm_15_8 = ep[15:8];
    if_a.pwm_duty_cycle  = d;
    if_b.en_reg_out_7_0  = eo[7:0];
    if_b.en_reg_out_15_8 = eo[15:8];
    if_b.en_reg_pwm_7_0  = ep[7:0];
    if_b.en_reg_pwm_15_8 = ep[15:8];
    if_b.pwm_duty_cycle  = d;
  endtask

  function automatic logic [15:0] model_out(input logic [15:0] eo, input logic [15:0] ep,
                                            input logic lvl);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (!eo[i])      r[i] = 1'b0;
      else if (!ep[i]) r[i] = 1'b1;
      else             r[i] = lvl;
    end
    return r;
  endfunction

  // Predict the next registered outputs, clock once, then compare.
  task automatic step();
    exp_t e;
    int   p_a;
    int   p_b;
    logic lvl_a;
    logic lvl_b;
    if (!rst_n) begin
      e.out_a = 16'h0000; e.ps_a = 1'b0;
      e.out_b = 16'h0000; e.ps_b = 1'b0;
    end else begin
      p_a = m_t % PER_A;
      p_b = m_t % PER_B;
      if (p_a == 0) m_duty_a = duty;
      if (p_b == 0) m_duty_b = duty;
      lvl_a   = (m_duty_a == 8'hFF) || ((p_a / DIV_A) < int'(m_duty_a));
      lvl_b   = (m_duty_b == 8'hFF) || ((p_b / DIV_B) < int'(m_duty_b));
      e.out_a = model_out(en_out, en_pwm, lvl_a);
      e.ps_a  = (p_a == 0);
      e.out_b = model_out(en_out, en_pwm, lvl_b);
      e.ps_b  = (p_b == 0);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (rst_n) m_t++;
    e = sb.pop_front();
    check("out_a", if_a.out, e.out_a);
    check("ps_a",  if_a.period_start, e.ps_a);
    check("out_b", if_b.out, e.out_b);
    check("ps_b",  if_b.period_start, e.ps_b);
  endtask

  function automatic logic obs_bit(input bit sel_b, input int ch);
    return sel_b ? if_b.out[ch] : if_a.out[ch];
  endfunction

  // Starting on the first sample of a period, count high samples over one
  // period and confirm the following sample opens the next period.
  task automatic measure(input string tag, input bit sel_b, input int ch, input int change_at,
                         input logic [7:0] new_duty, input int exp_highs);
    int plen;
    int highs;
    plen  = sel_b ? PER_B : PER_A;
    highs = int'(obs_bit(sel_b, ch));
    for (int i = 1; i < plen; i++) begin
      if (i == change_at) drive(en_out, en_pwm, new_duty);
      step();
      highs += int'(obs_bit(sel_b, ch));
    end
    check({tag, "_highs"}, highs, exp_highs);
    step();
    check({tag, "_next_ps"}, sel_b ? if_b.period_start : if_a.period_start, 1);
  endtask

  task automatic sync_a();
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!if_a.period_start && guard < 2 * PER_A);
    check("sync_a", if_a.period_start, 1);
  endtask

  task automatic sync_b_boundary();
    int guard;
    guard = 0;
    while ((m_t % PER_B) != 0 && guard < 2 * PER_B) begin
      step();
      guard++;
    end
    check("sync_b", m_t % PER_B, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    m_t      = 0;
    m_duty_a = 8'h00;
    m_duty_b = 8'h00;
    drive(16'h0001, 16'h0001, 8'h80);
    #1;
    check("rst_out_a", if_a.out, 16'h0000);
    check("rst_ps_a",  if_a.period_start, 0);
    check("rst_out_b", if_b.out, 16'h0000);
    repeat (3) step();

    // 50 % duty; first edge after release opens a period
    rst_n = 1'b1;
    step();
    check("rel_ps",  if_a.period_start, 1);
    check("rel_out", if_a.out[0], 1);
    measure("d80_p1", 1'b0, 0, -1, 8'h00, 512);
    measure("d80_p2", 1'b0, 0, -1, 8'h00, 512);

    // Extreme duties
    drive(16'h0001, 16'h0001, 8'h00);
    sync_a();
    measure("d00_p1", 1'b0, 0, -1, 8'h00, 0);
    measure("d00_p2", 1'b0, 0, -1, 8'h00, 0);
    drive(16'h0001, 16'h0001, 8'hFF);
    sync_a();
    measure("dff_p1", 1'b0, 0, -1, 8'h00, PER_A);
    measure("dff_p2", 1'b0, 0, -1, 8'h00, PER_A);
    drive(16'h0001, 16'h0001, 8'h01);
    sync_a();
    measure("d01", 1'b0, 0, -1, 8'h00, 4);

    // Static and off channels
    drive(16'hFFFF, 16'h00FF, 8'h40);
    sync_a();
    measure("static8", 1'b0, 8, -1, 8'h00, PER_A);
    measure("pwm0_d40", 1'b0, 0, -1, 8'h00, 256);
    drive(16'h7FFF, 16'h00FF, 8'h40);
    step();
    check("off15", if_a.out[15], 0);
    check("on14",  if_a.out[14], 1);
    drive(16'h7FF7, 16'h00FF, 8'h40);
    step();
    check("off3", if_a.out[3], 0);
    check("pwm2", if_a.out[2], 1);

    // Mid-period duty change waits for the next boundary
    drive(16'h0001, 16'h0001, 8'h40);
    sync_a();
    measure("chg_cur",  1'b0, 0, 400, 8'hC0, 256);
    measure("chg_next", 1'b0, 0, -1, 8'h00, 768);

    // Mid-period asynchronous reset
    drive(16'h0001, 16'h0001, 8'hFF);
    sync_a();
    repeat (600) step();
    check("pre_rst_out", if_a.out[0], 1);
    rst_n    = 1'b0;
    m_t      = 0;
    m_duty_a = 8'h00;
    m_duty_b = 8'h00;
    #1;
    check("async_out_a", if_a.out, 16'h0000);
    check("async_ps_a",  if_a.period_start, 0);
    check("async_out_b", if_b.out, 16'h0000);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rerel_ps",  if_a.period_start, 1);
    check("rerel_out", if_a.out[0], 1);
    measure("rerel_p1", 1'b0, 0, -1, 8'h00, PER_A);

    // CLK_DIV=1 instance
    drive(16'h0001, 16'h0001, 8'h10);
    sync_b_boundary();
    step();
    check("b_ps", if_b.period_start, 1);
    measure("b_d10", 1'b1, 0, -1, 8'h00, 16);
    step();
    sync_b_boundary();
    drive(16'h0001, 16'h0001, 8'h20);
    step();
    measure("b_pstart_cap", 1'b1, 0, -1, 8'h00, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Output stage fed directly by the SPI register file. It consumes the five configuration bytes: output enables, PWM-mode enables and duty cycle. It drives 16 chip outputs, each of which is forced low, held static high, or modulated by a shared 8-bit PWM. Duty-cycle updates are double-buffered and take effect only at a period boundary, so output waveforms never glitch.

## Interface
- CLK_DIV, 3000, clk cycles per PWM count step (≥1); PWM period = 256·CLK_DIV clk cycles
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  output enable, out[7:0]
- en_reg_out_15_8  input  8  output enable, out[15:8]
- en_reg_pwm_7_0  input  8  PWM-mode select, out[7:0]
- en_reg_pwm_15_8  input  8  PWM-mode select, out[15:8]
- pwm_duty_cycle  input  8  requested duty, 0x00 = 0 %, 0xFF = 100 %
- out  output  16  registered chip outputs
- period_start  output  1  one-clk pulse marking the first cycle of each PWM period

## Operation
- Inputs are synchronous to clk; no synchronisers needed.
- The prescaler counts presc 0..CLK_DIV-1 and wraps to 0. tick = (presc == CLK_DIV-1). With CLK_DIV=1, tick is asserted every cycle and presc is constant 0.
- The 8-bit PWM counter cnt advances on tick and wraps 255→0 with no extra cycle.
- pstart = (cnt == 0 && presc == 0), combinational.
- duty_shadow loads pwm_duty_cycle in every pstart cycle and holds otherwise.
- duty_eff = pstart ? pwm_duty_cycle : duty_shadow.
- pwm_raw = (duty_eff == 8'hFF) ? 1 : (cnt < duty_eff). Comparison is unsigned, 8-bit.
- Bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - en_out[i]=0 → 0, regardless of en_pwm[i]
  - en_out[i]=1, en_pwm[i]=0 → 1
  - en_out[i]=1, en_pwm[i]=1 → pwm_raw
- The out register samples this function every clk. period_start register samples pstart every clk.
- All 16 channels share one counter and one duty value.

## Timing
- Reset (asynchronous): presc=0, cnt=0, duty_shadow=0x00, out=16'h0000, period_start=0. All of these are immediate on rst_n low, including mid-period.
- First clk edge after release is a pstart cycle:
  - duty is captured
  - period_start=1
  - out reflects the new duty
- Latency: out and period_start lag their inputs and counter state by exactly one clk.
- Enable changes are visible on out at the next clk edge, mid-period included.
- Duty changes outside a pstart cycle are ignored until the next period. A value present during the pstart cycle is the one used for the whole period.
- PWM channel high time per period is duty·CLK_DIV clks for duty 0x00..0xFE. For duty 0xFF the channel is constant high, with no 1-count low gap.
- duty 0x00: constant low, no pulses.
- period_start: high one clk every 256·CLK_DIV clks, aligned with the rising edge of every PWM channel whose duty is > 0.
- Counters wrap freely and have no terminal state. Reset is the only way to realign phase.

## Test plan
1. **50 % duty:** CLK_DIV=4, duty=0x80, en_out[0]=en_pwm[0]=1 → out[0] high 512 clks, low 512, repeating. period_start pulses every 1024 clks, coincident with the out[0] rise.
2. **Extreme duties:** duty=0x00 → out[0] low for ≥2 periods. duty=0xFF → out[0] high continuously for ≥2 periods. duty=0x01 → high 4 clks per 1024.
3. **Static and off channels:** en_out=0xFFFF, en_pwm=0x00FF, duty=0x40 → out[15:8] constant high, out[7:0] PWM high 256/1024 clks. Then clear en_out[15] → out[15]=0 one clk later. Also check en_out[3]=0 with en_pwm[3]=1 → out[3]=0.
4. **Mid-period duty change:** duty 0x40, switched to 0xC0 at cnt≈100 → current period high 256 clks, next period high 768 clks, no extra edges.
5. **Mid-period reset:** assert rst_n low at cnt≈150 with outputs high → out=0 and period_start=0 immediately. On release, period_start and out rise on the first edge and the period restarts from cnt=0.
6. **CLK_DIV=1:** duty=0x10 → period 256 clks, high 16 clks. Capturing a duty change in the pstart cycle itself applies it to that period.
